rgb_stream_to_mem: RTL and testbench
====================================

// Module: rgb_stream_to_mem
// PURPOSE
//   Capture side of the 480x272 parallel RGB565 video interface. Samples an external
//   pixel clock, HSync, VSync and RGB bus in the 100 MHz domain, recovers frame timing
//   and writes one active frame into the frame-buffer BRAM write port. The readout
//   path scans that BRAM; the write packing matches it exactly.
// PARAMETERS
//   H_SYNC_WIDTH  40   HSync low pixels;        H_BACK_PORCH 4   pixels before active
//   H_ACTIVE_LEN  480  active pixels per line;  V_SYNC_WIDTH 10  VSync low lines
//   V_BACK_PORCH  2    lines before active;     V_ACTIVE_LEN 272 active lines per frame
// PORTS
//   iClk        in   1   100 MHz system clock
//   iRst_n      in   1   asynchronous reset, active low
//   iCapStart   in   1   1-cycle pulse: capture one frame
//   iCapCont    in   1   level: capture frames continuously while high
//   iVidPclk    in   1   external pixel clock, <= iClk/4, asynchronous to iClk
//   iVidHSync   in   1   HSync, active low
//   iVidVSync   in   1   VSync, active low
//   iVidR       in   5   red;  iVidG  in  6  green;  iVidB  in  5  blue
//   oMemWe      out  1   BRAM write enable, 1-cycle pulse per pixel
//   oMemAddr    out  17  BRAM write address, 0..130559
//   oMemData    out  16  write data {B[15:11], G[10:5], R[4:0]}
//   oBusy       out  1   high in ARM or CAPTURE
//   oFrameDone  out  1   1-cycle pulse after the last pixel of a frame is written
//   oFrameErr   out  1   1-cycle pulse when a frame restarts before it is complete
// BEHAVIOUR
//   Reset: all outputs 0, FSM = IDLE, counters 0, synchronizers 0.
//   Input sync: pclk, hsync and vsync each pass a 2-FF synchronizer. The RGB bus is
//     registered on the same 2 stages. Strobe = synced pclk rising edge (s2 & ~s3).
//     Strobe occurs 3 iClk after the pclk rise. All timing logic advances only on strobe.
//   Counters, on strobe:
//     - hsync fall (sampled high->low): h_cnt <= 0, v_cnt++.
//     - otherwise h_cnt++, saturating at 1023.
//     - vsync fall: v_cnt <= 0; this has priority over the hsync v_cnt++.
//   Active pixel: strobe and h_cnt in [44,524) and v_cnt in [12,284).
//     Counts are evaluated before the increment.
//   FSM:
//     IDLE: go to ARM when iCapStart=1 or iCapCont=1.
//     ARM: wait for the strobe with vsync fall; then addr <= 0 and go to CAPTURE.
//     CAPTURE, on an active pixel:
//       - write on the next iClk: oMemWe=1, oMemAddr=addr, oMemData=packed RGB.
//       - addr++ after the write.
//       - the write at addr 130559 moves to DONE.
//     CAPTURE, vsync fall before 130560 writes:
//       - 1-cycle oFrameErr pulse; addr <= 0; stay in CAPTURE (the new frame is captured).
//     DONE (1 cycle): oFrameDone=1; go to ARM if iCapCont=1, else IDLE.
//   iCapStart is ignored outside IDLE.
//   Dropping iCapCont mid-frame completes the current frame, then returns to IDLE.
//   oMemAddr holds its last value when oMemWe=0.
//   Pixels are not written in IDLE or ARM.
//   Reset mid-frame: immediate return to IDLE; no partial-frame recovery.
// TESTING
//   1. iCapStart pulse, pclk = iClk/16, one full frame of a pixel-index pattern
//      -> 130560 oMemWe pulses, addr 0..130559, data matches, one oFrameDone, FSM IDLE.
//   2. Pixel (h=44, v=12) RGB=(5'h1F, 6'h00, 5'h00) -> addr 0, data 16'h001F;
//      pixel (h=523, v=283) -> addr 130559.
//   3. iCapStart asserted mid-frame -> no writes until the next VSync fall,
//      then a full frame from addr 0.
//   4. iCapCont=1 for 3 frames -> 3 oFrameDone pulses, oBusy stays high;
//      drop iCapCont in frame 3 -> frame 3 completes, then IDLE.
//   5. VSync fall after 100 active lines -> one oFrameErr pulse, addr restarts at 0,
//      next frame completes normally.
//   6. Assert iRst_n low during line 50 -> all outputs 0 within 1 cycle; FSM IDLE.

Source files
------------

// File: rtl/rgb_stream_to_mem_if.sv
// Parallel RGB565 video bus: pixel clock, active-low syncs and colour components.
// The source drives through master, the capture block listens through slave.
interface rgb_stream_to_mem_if;
  logic       pclk;
  logic       hsync;
  logic       vsync;
  logic [4:0] r;
  logic [5:0] g;
  logic [4:0] b;

  modport master (output pclk, hsync, vsync, r, g, b);
  modport slave  (input  pclk, hsync, vsync, r, g, b);
endinterface

// File: rtl/rgb_stream_to_mem.sv
// Captures one active frame of an asynchronous RGB565 video stream into the
// frame-buffer BRAM write port, in raster order starting at address 0.
module rgb_stream_to_mem #(
  parameter int H_SYNC_WIDTH = 40,
  parameter int H_BACK_PORCH = 4,
  parameter int H_ACTIVE_LEN = 480,
  parameter int V_SYNC_WIDTH = 10,
  parameter int V_BACK_PORCH = 2,
  parameter int V_ACTIVE_LEN = 272
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iCapStart,
  input  logic                      iCapCont,
  rgb_stream_to_mem_if.slave        vid,
  output logic                      oMemWe,
  output logic [16:0]               oMemAddr,
  output logic [15:0]               oMemData,
  output logic                      oBusy,
  output logic                      oFrameDone,
  output logic                      oFrameErr
);

  localparam logic [9:0]  H_START   = 10'(H_SYNC_WIDTH + H_BACK_PORCH);
  localparam logic [9:0]  H_END     = 10'(H_SYNC_WIDTH + H_BACK_PORCH + H_ACTIVE_LEN);
  localparam logic [9:0]  V_START   = 10'(V_SYNC_WIDTH + V_BACK_PORCH);
  localparam logic [9:0]  V_END     = 10'(V_SYNC_WIDTH + V_BACK_PORCH + V_ACTIVE_LEN);
  localparam logic [16:0] ADDR_LAST = 17'(H_ACTIVE_LEN * V_ACTIVE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t      state, state_n;
  logic        pclk_s1, pclk_s2, pclk_s3;
  logic        hs_s1, hs_s2, hs_prev;
  logic        vs_s1, vs_s2, vs_prev;
  logic [15:0] rgb_s1, rgb_s2;
  logic [9:0]  h_cnt, v_cnt;
  logic [16:0] addr;
  logic        strobe, hs_fall, vs_fall, pix_active;
  logic        wr_en, addr_clr, restart;

  // Everything from the video bus is asynchronous; the RGB bus rides the same two
  // stages as pclk so it is stable whenever the strobe fires (pclk <= iClk/4).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pclk_s1 <= 1'b0;
      pclk_s2 <= 1'b0;
      pclk_s3 <= 1'b0;
      hs_s1   <= 1'b0;
      hs_s2   <= 1'b0;
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      rgb_s1  <= '0;
      rgb_s2  <= '0;
    end else begin
      pclk_s1 <= vid.pclk;
      pclk_s2 <= pclk_s1;
      pclk_s3 <= pclk_s2;
      hs_s1   <= vid.hsync;
      hs_s2   <= hs_s1;
      vs_s1   <= vid.vsync;
      vs_s2   <= vs_s1;
      rgb_s1  <= {vid.b, vid.g, vid.r};
      rgb_s2  <= rgb_s1;
    end
  end

  assign strobe     = pclk_s2 & ~pclk_s3;
  assign hs_fall    = strobe & hs_prev & ~hs_s2;
  assign vs_fall    = strobe & vs_prev & ~vs_s2;
  assign pix_active = strobe && (h_cnt >= H_START) && (h_cnt < H_END) &&
                      (v_cnt >= V_START) && (v_cnt < V_END);

  // Both counters saturate so a missing sync can never wrap back into the active window.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else if (strobe) begin
      hs_prev <= hs_s2;
      vs_prev <= vs_s2;
      if (hs_fall)             h_cnt <= '0;
      else if (h_cnt != '1)    h_cnt <= h_cnt + 10'd1;
      if (vs_fall)             v_cnt <= '0;
      else if (hs_fall && v_cnt != '1) v_cnt <= v_cnt + 10'd1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= S_IDLE;
    else         state <= state_n;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    addr_clr = 1'b0;
    restart  = 1'b0;
    case (state)
      S_IDLE:    if (iCapStart || iCapCont) state_n = S_ARM;
      S_ARM:     if (vs_fall) begin
                   addr_clr = 1'b1;
                   state_n  = S_CAPTURE;
                 end
      S_CAPTURE: if (vs_fall) begin
                   restart  = 1'b1;
                   addr_clr = 1'b1;
                 end else if (pix_active) begin
                   wr_en = 1'b1;
                   if (addr == ADDR_LAST) state_n = S_DONE;
                 end
      S_DONE:    state_n = iCapCont ? S_ARM : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      addr      <= '0;
      oMemWe    <= 1'b0;
      oMemAddr  <= '0;
      oMemData  <= '0;
      oFrameErr <= 1'b0;
    end else begin
      oMemWe    <= wr_en;
      oFrameErr <= restart;
      if (addr_clr)   addr <= '0;
      else if (wr_en) addr <= addr + 17'd1;
      if (wr_en) begin
        oMemAddr <= addr;
        oMemData <= rgb_s2;
      end
    end
  end

  // DONE is a one-cycle bridge back to ARM, so busy stays high across
  // back-to-back continuous frames.
  assign oBusy      = (state != S_IDLE);
  assign oFrameDone = (state == S_DONE);

endmodule

// File: tb/tb_rgb_stream_to_mem.sv
// Self-checking bench for rgb_stream_to_mem on a reduced video geometry: a frame
// generator pushes expected BRAM writes to a queue, a monitor pops and compares.
module tb_rgb_stream_to_mem;
  localparam int HS = 4, HBP = 2, HA = 8, HFP = 3;
  localparam int VS = 2, VBP = 1, VA = 4, VFP = 1;
  localparam int H_TOTAL = HS + HBP + HA + HFP;
  localparam int V_TOTAL = VS + VBP + VA + VFP;
  localparam int H_START = HS + HBP, H_END = H_START + HA;
  localparam int V_START = VS + VBP, V_END = V_START + VA;

  typedef enum {A_NONE, A_START, A_DROP_CONT, A_RESET} act_t;
  typedef struct {
    int          line;
    int          pix;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic [16:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  logic        clk, rst_n, cap_start, cap_cont;
  logic        mem_we, busy, frame_done, frame_err;
  logic [16:0] mem_addr;
  logic [15:0] mem_data;

  rgb_stream_to_mem_if vid ();

  rgb_stream_to_mem #(
    .H_SYNC_WIDTH(HS), .H_BACK_PORCH(HBP), .H_ACTIVE_LEN(HA),
    .V_SYNC_WIDTH(VS), .V_BACK_PORCH(VBP), .V_ACTIVE_LEN(VA)
  ) dut (
    .iClk(clk), .iRst_n(rst_n), .iCapStart(cap_start), .iCapCont(cap_cont),
    .vid(vid), .oMemWe(mem_we), .oMemAddr(mem_addr), .oMemData(mem_data),
    .oBusy(busy), .oFrameDone(frame_done), .oFrameErr(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  int          n_writes = 0, n_done = 0, n_err = 0, busy_low = 0;
  bit          busy_watch = 1'b0;
  bit          use_table = 1'b0;
  int          half = 4;
  int          seed = 0;
  logic [32:0] exp_q[$];
  logic [32:0] sb_e;
  logic [15:0] wr_log[32];
  bit          wr_seen[32];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        n_writes++;
        if (mem_addr < 17'd32) begin
          wr_log[mem_addr[4:0]]  = mem_data;
          wr_seen[mem_addr[4:0]] = 1'b1;
        end
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_write: got addr %0d data %h, expected no write",
                   mem_addr, mem_data);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_addr", 32'(mem_addr), 32'(sb_e[32:16]));
          check("sb_data", 32'(mem_data), 32'(sb_e[15:0]));
        end
      end
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
      if (busy_watch && !busy) busy_low++;
    end
  end

  function automatic logic [15:0] pix_val(input int l, input int p);
    if (use_table)
      foreach (vecs[i])
        if (vecs[i].line == l && vecs[i].pix == p) return {vecs[i].b, vecs[i].g, vecs[i].r};
    return 16'(seed * 40503 + l * 1031 + p * 97);
  endfunction

  // A pixel at position p is judged with the h count left by the previous strobe,
  // so active pixels sit one position after the h window.
  function automatic bit is_active(input int l, input int p);
    return (l >= V_START) && (l < V_END) && (p - 1 >= H_START) && (p - 1 < H_END);
  endfunction

  task automatic drive_pixel(input bit hs, input bit vs, input logic [15:0] val);
    vid.pclk  = 1'b0;
    vid.hsync = hs;
    vid.vsync = vs;
    vid.r     = val[4:0];
    vid.g     = val[10:5];
    vid.b     = val[15:11];
    repeat (half) @(negedge clk);
    vid.pclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic pulse_start();
    cap_start = 1'b1;
    @(negedge clk);
    cap_start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},   32'(mem_we),     0);
    check({tag, "_addr"}, 32'(mem_addr),   0);
    check({tag, "_data"}, 32'(mem_data),   0);
    check({tag, "_busy"}, 32'(busy),       0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_err"},  32'(frame_err),  0);
  endtask

  task automatic drive_frame(input int n_lines, input bit push, input int act_line, input act_t act);
    int wa = 0;
    logic [15:0] v;
    seed++;
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < H_TOTAL; p++) begin
        if (l == act_line && p == H_TOTAL / 2) begin
          case (act)
            A_START:     pulse_start();
            A_DROP_CONT: begin busy_watch = 1'b0; cap_cont = 1'b0; end
            A_RESET: begin
              rst_n = 1'b0;
              #1;
              check_outputs_zero("midrst");
              repeat (3) @(negedge clk);
              exp_q.delete();
              rst_n = 1'b1;
              return;
            end
            default: ;
          endcase
        end
        v = pix_val(l, p);
        if (push && is_active(l, p)) begin
          exp_q.push_back({17'(wa), v});
          wa++;
        end
        drive_pixel(p >= HS, l >= VS, v);
      end
    end
  endtask

  task automatic idle_pixels(input int n);
    for (int i = 0; i < n; i++) drive_pixel(1'b1, 1'b1, 16'h0000);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, d0, e0;
    vecs[0] = '{3,  7, 5'h1F, 6'h00, 5'h00, 17'd0,  16'h001F};
    vecs[1] = '{3,  8, 5'h00, 6'h3F, 5'h00, 17'd1,  16'h07E0};
    vecs[2] = '{3,  9, 5'h00, 6'h00, 5'h1F, 17'd2,  16'hF800};
    vecs[3] = '{3, 14, 5'h01, 6'h01, 5'h01, 17'd7,  16'h0821};
    vecs[4] = '{4,  7, 5'h10, 6'h20, 5'h08, 17'd8,  16'h4410};
    vecs[5] = '{6, 14, 5'h15, 6'h2A, 5'h0A, 17'd31, 16'h5555};

    rst_n = 1'b0; cap_start = 1'b0; cap_cont = 1'b0;
    vid.pclk = 1'b0; vid.hsync = 1'b1; vid.vsync = 1'b1;
    vid.r = '0; vid.g = '0; vid.b = '0;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle_pixels(4);

    // 1: single frame at pclk = iClk/16
    half = 8;
    w0 = n_writes; d0 = n_done; e0 = n_err;
    pulse_start();
    drive_frame(V_TOTAL, 1'b1, -1, A_NONE);
    wait_drain("t1_drain");
    check("t1_writes", 32'(n_writes - w0), 32);
    check("t1_done", 32'(n_done - d0), 1);
    check("t1_err", 32'(n_err - e0), 0);
    check("t1_idle", 32'(busy), 0);
    half = 4;

    // 2: corner pixels and packing, table-driven
    foreach (wr_seen[i]) wr_seen[i] = 1'b0;
    use_table = 1'b1;
    pulse_start();
    drive_frame(V_TOTAL, 1'b1, -1, A_NONE);
    use_table = 1'b0;
    wait_drain("t2_drain");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_seen_%0d", i), 32'(wr_seen[vecs[i].exp_addr[4:0]]), 1);
      check($sformatf("t2_data_%0d", i), 32'(wr_log[vecs[i].exp_addr[4:0]]), 32'(vecs[i].exp_data));
    end

    // 3: start mid-frame waits for the next vsync fall
    w0 = n_writes; d0 = n_done;
    drive_frame(V_TOTAL, 1'b0, 4, A_START);
    check("t3_no_early_writes", 32'(n_writes - w0), 0);
    drive_frame(V_TOTAL, 1'b1, -1, A_NONE);
    wait_drain("t3_drain");
    check("t3_writes", 32'(n_writes - w0), 32);
    check("t3_done", 32'(n_done - d0), 1);

    // 4: continuous for three frames, dropped during the third
    w0 = n_writes; d0 = n_done; busy_low = 0;
    cap_cont = 1'b1;
    @(negedge clk);
    busy_watch = 1'b1;
    drive_frame(V_TOTAL, 1'b1, -1, A_NONE);
    drive_frame(V_TOTAL, 1'b1, -1, A_NONE);
    drive_frame(V_TOTAL, 1'b1, 4, A_DROP_CONT);
    wait_drain("t4_drain");
    check("t4_busy_low_samples", 32'(busy_low), 0);
    check("t4_done", 32'(n_done - d0), 3);
    drive_frame(V_TOTAL, 1'b0, -1, A_NONE);
    check("t4_writes", 32'(n_writes - w0), 96);
    check("t4_idle", 32'(busy), 0);

    // 5: vsync restarts the frame after two active lines
    w0 = n_writes; d0 = n_done; e0 = n_err;
    pulse_start();
    drive_frame(V_START + 2, 1'b1, -1, A_NONE);
    drive_frame(V_TOTAL, 1'b1, -1, A_NONE);
    wait_drain("t5_drain");
    check("t5_err", 32'(n_err - e0), 1);
    check("t5_done", 32'(n_done - d0), 1);
    check("t5_writes", 32'(n_writes - w0), 2 * HA + 32);

    // 6: reset mid-frame, then a clean capture
    pulse_start();
    drive_frame(V_TOTAL, 1'b1, 5, A_RESET);
    idle_pixels(4);
    check("t6_idle_after_rst", 32'(busy), 0);
    w0 = n_writes; d0 = n_done;
    pulse_start();
    drive_frame(V_TOTAL, 1'b1, -1, A_NONE);
    wait_drain("t6_drain");
    check("t6_writes", 32'(n_writes - w0), 32);
    check("t6_done", 32'(n_done - d0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
